fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch initiator for the dual-port `Memory` instruction port: owns the program counter, drives `I_addr`, and samples `I_data` to build 1-byte and 2-byte instructions for the decode stage of the pipeline. On reset it loads the start address from the reset vector at address 0. It supports decode-side stall and execute-side redirect (flush).

## Interface
- `ADDR_WIDTH`, 8, instruction address width; the PC width.
- `DATA_WIDTH`, 8, memory word and opcode width.
- `LONG_OPC`, 4'hC, value of `I_data[7:4]` that marks a 2-byte instruction.

- `clk` in 1: single clock, all state on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `I_addr` out ADDR_WIDTH: address to the memory instruction port, combinational from state/PC.
- `I_data` in DATA_WIDTH: memory read data; asynchronous read, valid in the same cycle as `I_addr`.
- `stall` in 1: decode not ready; freeze the unit.
- `flush_en` in 1: redirect fetch.
- `flush_addr` in ADDR_WIDTH: redirect target.
- `instr` out DATA_WIDTH: registered opcode byte.
- `imm` out DATA_WIDTH: registered immediate byte; 0 for 1-byte instructions.
- `instr_valid` out 1: `instr`/`imm`/`pc_out` hold a new instruction this cycle.
- `pc_out` out ADDR_WIDTH: address of the first byte of `instr`.
- `pc_next` out ADDR_WIDTH: address following the full instruction (PC+1 or PC+2), used for the call return address.

## Operation
- States:
  - RST_VEC: `I_addr`=0.
  - FETCH1: `I_addr`=PC; opcode byte.
  - FETCH2: `I_addr`=PC; immediate byte.
- Internal registers: PC; opcode hold register `opc_q`; PC of the opcode byte `pc1_q`.
- Priority per cycle: `rst` > `flush_en` > `stall` > normal.
- RST_VEC: PC <= `I_data` (contents of Mem[0]), `instr_valid`<=0, then FETCH1.
- FETCH1, low nibble irrelevant:
  - `I_data[7:4]` != LONG_OPC:
    - `instr`<=I_data, `imm`<=0, `pc_out`<=PC, `pc_next`<=PC+1.
    - `instr_valid`<=1, PC<=PC+1, stay in FETCH1.
  - `I_data[7:4]` == LONG_OPC:
    - `opc_q`<=I_data, `pc1_q`<=PC, PC<=PC+1.
    - `instr_valid`<=0, go to FETCH2.
- FETCH2:
  - `instr`<=opc_q, `imm`<=I_data, `pc_out`<=pc1_q, `pc_next`<=PC+1.
  - `instr_valid`<=1, PC<=PC+1, go to FETCH1.
- Stall: PC, state, `opc_q`, and all outputs hold their values, including `instr_valid` (decode re-sees the same instruction). `I_addr` stays stable.
- Flush:
  - PC<=flush_addr, state<=FETCH1, `instr_valid`<=0.
  - A pending FETCH2 is abandoned and `opc_q` is discarded.
  - Flush overrides stall.
- PC arithmetic is modulo 2^ADDR_WIDTH: 8'hFF+1 = 8'h00. A 2-byte instruction at 8'hFF takes its immediate from 8'h00.

## Timing
- Reset values:
  - `instr`=0, `imm`=0, `instr_valid`=0, `pc_out`=0, `pc_next`=0.
  - PC=0, state=RST_VEC, so `I_addr`=0.
- After `rst` falls: 1 cycle in RST_VEC, then the first `instr_valid` pulse 1 cycle later (1-byte instruction) or 2 cycles later (2-byte instruction).
- Steady state: one 1-byte instruction per cycle. A 2-byte instruction takes 2 cycles, with a `instr_valid`=0 bubble on the first.
- Flush: asserting `flush_en` at edge N gives `instr_valid`=0 after N. The target instruction is valid after N+1 (1-byte case).
- `rst` asserted mid-instruction: everything returns to reset values at that edge. There is no partial output.

## Configuration
- `FETCH_INTR_EN`: when defined, adds the following ports:
  - `intr` in 1
  - `intr_ack` out 1
  - `intr_pc` out ADDR_WIDTH
- Interrupt entry:
  - When `intr`=1 in FETCH1 with no flush and no stall, enter state INTR_VEC for 1 cycle.
  - The edge that enters INTR_VEC registers `intr_pc`<=PC (the return address).
- INTR_VEC:
  - Drives `I_addr`=1 and loads PC<=I_data (Mem[1]).
  - Registers `intr_ack`<=1 for exactly one cycle and `instr_valid`<=0, then goes to FETCH1.
- `intr` is ignored during FETCH2, RST_VEC, and INTR_VEC.
- Undefined: none of these ports or the state exist, and behaviour is exactly as above.

## Test plan
- Reset vector: Mem[0]=8'h10, Mem[8'h10]=8'h01, Mem[8'h11]=8'h02, pulse `rst` -> I_addr 0 then 8'h10. Valid `instr`=01 with pc_out=10, then `instr`=02 with pc_out=11, on consecutive cycles.
- 2-byte: Mem[8'h10]=8'hC3, Mem[8'h11]=8'h55, Mem[8'h12]=8'h07 -> one bubble, then `instr`=C3, `imm`=55, pc_out=10, pc_next=12; next cycle `instr`=07.
- Stall: assert `stall` for 3 cycles while `instr`=01 is valid -> outputs and `I_addr` frozen, `instr_valid` stays 1. Release -> `instr`=02.
- Flush during FETCH2: `flush_en`=1, `flush_addr`=8'h40 while fetching the C3 immediate -> `instr_valid`=0, C3 never emitted, next `instr`=Mem[8'h40] with pc_out=40.
- Wrap: PC=8'hFF, Mem[8'hFF]=8'hC1, Mem[0]=8'hAA -> `instr`=C1, `imm`=AA, pc_next=8'h01.
- `FETCH_INTR_EN` defined: Mem[1]=8'h80, `intr` pulsed at PC=8'h12 -> `intr_ack` for 1 cycle, `intr_pc`=12, next valid pc_out=80.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-fetch bundle between fetch_unit, the memory instruction port and decode/execute.
// Interrupt signals exist only when FETCH_INTR_EN is defined.
interface fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] I_addr;
  logic [DATA_WIDTH-1:0] I_data;
  logic                  stall;
  logic                  flush_en;
  logic [ADDR_WIDTH-1:0] flush_addr;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] imm;
  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [ADDR_WIDTH-1:0] pc_next;
`ifdef FETCH_INTR_EN
  logic                  intr;
  logic                  intr_ack;
  logic [ADDR_WIDTH-1:0] intr_pc;
`endif

  modport master (
    output I_addr, instr, imm, instr_valid, pc_out, pc_next,
    input  I_data, stall, flush_en, flush_addr
`ifdef FETCH_INTR_EN
    , input intr, output intr_ack, intr_pc
`endif
  );

  modport slave (
    input  I_addr, instr, imm, instr_valid, pc_out, pc_next,
    output I_data, stall, flush_en, flush_addr
`ifdef FETCH_INTR_EN
    , output intr, input intr_ack, intr_pc
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, loads the reset vector from Mem[0], assembles 1/2-byte
// instructions with stall and flush. Optional interrupt entry via Mem[1] under FETCH_INTR_EN.
module fetch_unit #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 8,
  parameter logic [3:0] LONG_OPC   = 4'hC
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    RST_VEC,
    FETCH1,
    FETCH2
`ifdef FETCH_INTR_EN
    , INTR_VEC
`endif
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] pc, pc_d, pc_inc;
  logic [ADDR_WIDTH-1:0] pc1_q, pc1_d;
  logic [DATA_WIDTH-1:0] opc_q, opc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
`ifdef FETCH_INTR_EN
  logic                  intr_ack_q, intr_ack_d;
  logic [ADDR_WIDTH-1:0] intr_pc_q, intr_pc_d;
`endif

  // Modulo 2^ADDR_WIDTH, so a long instruction at the top address fetches its immediate from 0
  assign pc_inc = pc + ADDR_WIDTH'(1);

  always_comb begin
    bus.I_addr = pc;
    case (state)
      RST_VEC:  bus.I_addr = '0;
`ifdef FETCH_INTR_EN
      INTR_VEC: bus.I_addr = ADDR_WIDTH'(1);
`endif
      default:  bus.I_addr = pc;
    endcase
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pc1_d     = pc1_q;
    opc_d     = opc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    vld_d     = vld_q;
    pc_out_d  = pc_out_q;
    pc_next_d = pc_next_q;
`ifdef FETCH_INTR_EN
    intr_ack_d = intr_ack_q;
    intr_pc_d  = intr_pc_q;
`endif
    if (bus.flush_en) begin
      pc_d    = bus.flush_addr;
      state_d = FETCH1;
      vld_d   = 1'b0;
`ifdef FETCH_INTR_EN
      intr_ack_d = 1'b0;
`endif
    end else if (!bus.stall) begin
      vld_d = 1'b0;
`ifdef FETCH_INTR_EN
      intr_ack_d = 1'b0;
`endif
      case (state)
        RST_VEC: begin
          pc_d    = ADDR_WIDTH'(bus.I_data);
          state_d = FETCH1;
        end
        FETCH1: begin
`ifdef FETCH_INTR_EN
          if (bus.intr) begin
            intr_pc_d = pc;
            state_d   = INTR_VEC;
          end else
`endif
          if (bus.I_data[7:4] == LONG_OPC) begin
            opc_d   = bus.I_data;
            pc1_d   = pc;
            pc_d    = pc_inc;
            state_d = FETCH2;
          end else begin
            instr_d   = bus.I_data;
            imm_d     = '0;
            pc_out_d  = pc;
            pc_next_d = pc_inc;
            vld_d     = 1'b1;
            pc_d      = pc_inc;
          end
        end
        FETCH2: begin
          instr_d   = opc_q;
          imm_d     = bus.I_data;
          pc_out_d  = pc1_q;
          pc_next_d = pc_inc;
          vld_d     = 1'b1;
          pc_d      = pc_inc;
          state_d   = FETCH1;
        end
`ifdef FETCH_INTR_EN
        INTR_VEC: begin
          pc_d       = ADDR_WIDTH'(bus.I_data);
          intr_ack_d = 1'b1;
          state_d    = FETCH1;
        end
`endif
        default: state_d = RST_VEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_VEC;
      pc        <= '0;
      pc1_q     <= '0;
      opc_q     <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      vld_q     <= 1'b0;
      pc_out_q  <= '0;
      pc_next_q <= '0;
`ifdef FETCH_INTR_EN
      intr_ack_q <= 1'b0;
      intr_pc_q  <= '0;
`endif
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pc1_q     <= pc1_d;
      opc_q     <= opc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      vld_q     <= vld_d;
      pc_out_q  <= pc_out_d;
      pc_next_q <= pc_next_d;
`ifdef FETCH_INTR_EN
      intr_ack_q <= intr_ack_d;
      intr_pc_q  <= intr_pc_d;
`endif
    end
  end

  assign bus.instr       = instr_q;
  assign bus.imm         = imm_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.pc_next     = pc_next_q;
`ifdef FETCH_INTR_EN
  assign bus.intr_ack    = intr_ack_q;
  assign bus.intr_pc     = intr_pc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset vector, stall, 2-byte, flush, wrap and mid-instruction reset.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LONG_OPC(4'hC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.I_data = mem[bus.I_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] ins,
                         input logic [7:0] im, input logic [7:0] pco, input logic [7:0] pcn);
    chk({tag, ".valid"},   {7'd0, bus.instr_valid}, {7'd0, v});
    chk({tag, ".instr"},   bus.instr,   ins);
    chk({tag, ".imm"},     bus.imm,     im);
    chk({tag, ".pc_out"},  bus.pc_out,  pco);
    chk({tag, ".pc_next"}, bus.pc_next, pcn);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02;
    mem[8'h12] = 8'hC3; mem[8'h13] = 8'h55; mem[8'h14] = 8'h07;
    mem[8'h15] = 8'hC3; mem[8'h16] = 8'h66;
    mem[8'h40] = 8'h09; mem[8'h41] = 8'hC3; mem[8'h42] = 8'h77;
    mem[8'hFF] = 8'hC1;
    mem[8'hAA] = 8'h21; mem[8'hAB] = 8'h22;
    rst = 1'b1; bus.stall = 1'b0; bus.flush_en = 1'b0; bus.flush_addr = 8'h00;
`ifdef FETCH_INTR_EN
    bus.intr = 1'b0;
`endif
    step(); step();
    chk_out("reset", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.I_addr", bus.I_addr, 8'h00);

    rst = 1'b0;
    step();
    chk("rstvec.I_addr", bus.I_addr, 8'h10);
    chk("rstvec.valid", {7'd0, bus.instr_valid}, 8'h00);
    step();
    chk_out("first", 1'b1, 8'h01, 8'h00, 8'h10, 8'h11);

    // Hold the 01 instruction for three stalled edges
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1'b1, 8'h01, 8'h00, 8'h10, 8'h11);
      chk("stall.I_addr", bus.I_addr, 8'h11);
    end
    bus.stall = 1'b0;
    step();
    chk_out("second", 1'b1, 8'h02, 8'h00, 8'h11, 8'h12);

    step();
    chk("long.bubble", {7'd0, bus.instr_valid}, 8'h00);
    chk("long.I_addr", bus.I_addr, 8'h13);
    step();
    chk_out("long", 1'b1, 8'hC3, 8'h55, 8'h12, 8'h14);
    step();
    chk_out("after_long", 1'b1, 8'h07, 8'h00, 8'h14, 8'h15);

    // C3 at 0x15 begins; flush while its immediate is being fetched
    step();
    chk("fl.bubble", {7'd0, bus.instr_valid}, 8'h00);
    bus.flush_en = 1'b1; bus.flush_addr = 8'h40;
    step();
    chk("fl.valid", {7'd0, bus.instr_valid}, 8'h00);
    chk("fl.I_addr", bus.I_addr, 8'h40);
    bus.flush_en = 1'b0;
    step();
    chk_out("fl.target", 1'b1, 8'h09, 8'h00, 8'h40, 8'h41);

    mem[8'h00] = 8'hAA;
    bus.flush_en = 1'b1; bus.flush_addr = 8'hFF;
    step();
    chk("wrap.I_addr", bus.I_addr, 8'hFF);
    bus.flush_en = 1'b0;
    step();
    chk("wrap.bubble", {7'd0, bus.instr_valid}, 8'h00);
    chk("wrap.I_addr0", bus.I_addr, 8'h00);
    step();
    chk_out("wrap", 1'b1, 8'hC1, 8'hAA, 8'hFF, 8'h01);

    // Flush wins over a simultaneous stall
    bus.stall = 1'b1; bus.flush_en = 1'b1; bus.flush_addr = 8'h40;
    step();
    chk("fls.valid", {7'd0, bus.instr_valid}, 8'h00);
    chk("fls.I_addr", bus.I_addr, 8'h40);
    bus.flush_en = 1'b0;
    step();
    chk("fls.hold_valid", {7'd0, bus.instr_valid}, 8'h00);
    chk("fls.hold_I_addr", bus.I_addr, 8'h40);
    bus.stall = 1'b0;
    step();
    chk_out("fls.target", 1'b1, 8'h09, 8'h00, 8'h40, 8'h41);

    step();
    chk("mid.bubble", {7'd0, bus.instr_valid}, 8'h00);
    rst = 1'b1;
    step();
    chk_out("midrst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("midrst.I_addr", bus.I_addr, 8'h00);
    rst = 1'b0;
    step();
    chk("vec2.I_addr", bus.I_addr, 8'hAA);
    step();
    chk_out("vec2.a", 1'b1, 8'h21, 8'h00, 8'hAA, 8'hAB);
    step();
    chk_out("vec2.b", 1'b1, 8'h22, 8'h00, 8'hAB, 8'hAC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
